// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM driven by one shared period counter.
// Duty targets are double-buffered and become active only at the period wrap.
// An optional slew limit ramps the active duty toward its target by a bounded
// amount on each wrap.
module pwm_multi #(
    parameter int unsigned         CHANNELS = 4,
    parameter int unsigned         STEPS    = 100,
    parameter int unsigned         PRESCALE = 1,
    parameter int unsigned         SLEW     = 0,
    parameter logic [CHANNELS-1:0] INVERT   = '0,
    localparam int unsigned        DUTY_W   = $clog2(STEPS + 1),
    localparam int unsigned        CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick_enable,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [DUTY_W-1:0]   wr_duty,
    output logic [CHANNELS-1:0] out,
    output logic                period_start,
    output logic                duty_busy
);

    localparam int unsigned       PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(STEPS - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(STEPS);
    // Slew steps larger than the duty range behave like an immediate load.
    localparam int unsigned       SLEW_C   = (SLEW > STEPS) ? STEPS : SLEW;
    localparam logic [DUTY_W:0]   SLEW_LIM = (DUTY_W + 1)'(SLEW_C);

    logic [PRE_W-1:0]  pre_cnt, pre_nxt;
    logic [DUTY_W-1:0] cnt, cnt_nxt;
    logic [DUTY_W-1:0] target     [CHANNELS];
    logic [DUTY_W-1:0] target_nxt [CHANNELS];
    logic [DUTY_W-1:0] active     [CHANNELS];
    logic [DUTY_W-1:0] active_nxt [CHANNELS];
    logic [DUTY_W-1:0] wr_sat;
    logic              wr_ok;
    logic              step, wrap;
    logic [CHANNELS-1:0] out_nxt;
    logic              busy_nxt;

    // One wrap-time update of an active duty: immediate, or bounded step without overshoot.
    function automatic logic [DUTY_W-1:0] slew_step(input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W-1:0] act);
        logic [DUTY_W:0] t, a, diff;
        t = {1'b0, tgt};
        a = {1'b0, act};
        if (SLEW == 0) begin
            return tgt;
        end
        if (t > a) begin
            diff = t - a;
            if (diff > SLEW_LIM) diff = SLEW_LIM;
            a = a + diff;
        end else begin
            diff = a - t;
            if (diff > SLEW_LIM) diff = SLEW_LIM;
            a = a - diff;
        end
        return a[DUTY_W-1:0];
    endfunction

    // Prescaler and period counter next-state; wrap marks the period boundary edge.
    always_comb begin
        step    = 1'b0;
        pre_nxt = pre_cnt;
        if (tick_enable) begin
            if (pre_cnt == PRE_LAST) begin
                pre_nxt = '0;
                step    = 1'b1;
            end else begin
                pre_nxt = pre_cnt + 1'b1;
            end
        end
        wrap    = step && (cnt == CNT_LAST);
        cnt_nxt = cnt;
        if (step) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
        end
    end

    // Target writes, wrap-time active loads, and the output/busy values they imply.
    always_comb begin
        wr_sat   = (wr_duty > DUTY_MAX) ? DUTY_MAX : wr_duty;
        wr_ok    = wr_en && (32'(wr_chan) < CHANNELS);
        out_nxt  = '0;
        busy_nxt = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            target_nxt[i] = target[i];
            if (wr_ok && (wr_chan == CH_W'(i))) begin
                target_nxt[i] = wr_sat;
            end
            // The wrap load sees the pre-edge target, so a write in the wrap cycle waits a period.
            active_nxt[i] = wrap ? slew_step(target[i], active[i]) : active[i];
            out_nxt[i]    = INVERT[i] ^ (ch_en[i] & (cnt_nxt < active_nxt[i]));
            busy_nxt      = busy_nxt | (active_nxt[i] != target_nxt[i]);
        end
    end

    // State and registered outputs; reset forces every output to its inactive level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                target[i] <= '0;
                active[i] <= '0;
            end
            out          <= INVERT;
            period_start <= 1'b0;
            duty_busy    <= 1'b0;
        end else begin
            pre_cnt      <= pre_nxt;
            cnt          <= cnt_nxt;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                target[i] <= target_nxt[i];
                active[i] <= active_nxt[i];
            end
            out          <= out_nxt;
            period_start <= wrap;
            duty_busy    <= busy_nxt;
        end
    end

endmodule
